// File: rtl/qcv_pkg.sv
// rtl/qcv_pkg.sv - shared types for the qcv trap-sequencing controller
//
// Purpose: FSM state encoding, PC-mux select encoding and exception cause
// codes shared by the controller and anything that decodes its outputs.
// Ports: none (package).

package qcv_pkg;

  typedef enum logic [2:0] {
    CTRL_RESET       = 3'd0,
    CTRL_BOOT_SET    = 3'd1,
    CTRL_FIRST_FETCH = 3'd2,
    CTRL_DECODE      = 3'd3,
    CTRL_FLUSH       = 3'd4,
    CTRL_SLEEP       = 3'd5
  } ctrl_fsm_e;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_EXC  = 2'd1,
    PC_ERET = 2'd2
  } pc_mux_e;

  typedef enum logic [6:0] {
    EXC_INSTR_ACCESS_FAULT = 7'd1,
    EXC_ILLEGAL_INSN       = 7'd2,
    EXC_BREAKPOINT         = 7'd3,
    EXC_LOAD_ACCESS_FAULT  = 7'd5,
    EXC_STORE_ACCESS_FAULT = 7'd7,
    EXC_ECALL_MMODE        = 7'd11
  } exc_cause_e;

endpackage

// File: rtl/qcv_controller.sv
// rtl/qcv_controller.sv - trap sequencing, boot and WFI sleep for the qcv core
//
// Purpose: watches the ID-stage instruction and the LSU for exceptions, MRET
// and WFI; drives PC redirect, ID flush/halt toward the pipeline and the
// exception-save strobes, mcause and mtval toward the CSR file.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fetch_enable_i           start request, sampled only in RESET
//   instr_valid_i, instr_i   ID instruction valid / word (mtval for illegal)
//   pc_id_i                  ID PC (mtval for fetch error)
//   instr_fetch_err_i, illegal_insn_i, ecall_insn_i, ebreak_insn_i,
//   mret_insn_i, wfi_insn_i  ID instruction classification
//   lsu_load_err_i, lsu_store_err_i, lsu_addr_i   LSU access faults
//   irq_pending_i            wake-up from WFI sleep
//   ctrl_busy_o, instr_req_o, pc_set_o, pc_mux_o, flush_id_o, halt_id_o
//                            pipeline control
//   csr_mtvec_init_o, csr_save_if_o, csr_save_id_o, csr_save_cause_o,
//   csr_mcause_o, csr_mtval_o                    CSR file trap interface

module qcv_controller
  import qcv_pkg::*;
#(
  parameter bit WfiEnable = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_id_i,
  input  logic        instr_fetch_err_i,
  input  logic        illegal_insn_i,
  input  logic        ecall_insn_i,
  input  logic        ebreak_insn_i,
  input  logic        mret_insn_i,
  input  logic        wfi_insn_i,
  input  logic        lsu_load_err_i,
  input  logic        lsu_store_err_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        irq_pending_i,
  output logic        ctrl_busy_o,
  output logic        instr_req_o,
  output logic        pc_set_o,
  output logic [1:0]  pc_mux_o,
  output logic        flush_id_o,
  output logic        halt_id_o,
  output logic        csr_mtvec_init_o,
  output logic        csr_save_if_o,
  output logic        csr_save_id_o,
  output logic        csr_save_cause_o,
  output logic [6:0]  csr_mcause_o,
  output logic [31:0] csr_mtval_o
);

  ctrl_fsm_e   state_q, state_d;
  logic        exc_flag_q, exc_flag_d;
  logic        eret_flag_q, eret_flag_d;
  logic [6:0]  mcause_q;
  logic [31:0] mtval_q;

  logic        exc_req;
  exc_cause_e  exc_cause;
  logic [31:0] exc_val;
  logic        exc_latch;
  pc_mux_e     pc_mux;

  // Exception priority encoder. ID-side sources only count with a valid
  // instruction; LSU faults arrive for an instruction that has already left
  // the decoder's view, so they are taken regardless of instr_valid_i.
  always_comb begin
    exc_req   = 1'b1;
    exc_cause = EXC_INSTR_ACCESS_FAULT;
    exc_val   = '0;
    if (instr_valid_i && instr_fetch_err_i) begin
      exc_cause = EXC_INSTR_ACCESS_FAULT;
      exc_val   = pc_id_i;
    end else if (instr_valid_i && illegal_insn_i) begin
      exc_cause = EXC_ILLEGAL_INSN;
      exc_val   = instr_i;
    end else if (instr_valid_i && ecall_insn_i) begin
      exc_cause = EXC_ECALL_MMODE;
    end else if (instr_valid_i && ebreak_insn_i) begin
      exc_cause = EXC_BREAKPOINT;
    end else if (lsu_store_err_i) begin
      exc_cause = EXC_STORE_ACCESS_FAULT;
      exc_val   = lsu_addr_i;
    end else if (lsu_load_err_i) begin
      exc_cause = EXC_LOAD_ACCESS_FAULT;
      exc_val   = lsu_addr_i;
    end else begin
      exc_req   = 1'b0;
    end
  end

  // Next-state and outputs. Outputs are decoded from the current state (plus
  // the ID/LSU inputs in DECODE), so an asynchronous reset into RESET drives
  // every control output low in the same instant.
  always_comb begin
    state_d          = state_q;
    exc_flag_d       = exc_flag_q;
    eret_flag_d      = eret_flag_q;
    exc_latch        = 1'b0;
    pc_mux           = PC_BOOT;
    ctrl_busy_o      = 1'b0;
    instr_req_o      = 1'b0;
    pc_set_o         = 1'b0;
    flush_id_o       = 1'b0;
    halt_id_o        = 1'b0;
    csr_mtvec_init_o = 1'b0;
    csr_save_id_o    = 1'b0;
    csr_save_cause_o = 1'b0;

    case (state_q)
      CTRL_RESET: begin
        if (fetch_enable_i) begin
          csr_mtvec_init_o = 1'b1;
          state_d          = CTRL_BOOT_SET;
        end
      end

      CTRL_BOOT_SET: begin
        ctrl_busy_o = 1'b1;
        instr_req_o = 1'b1;
        pc_set_o    = 1'b1;
        pc_mux      = PC_BOOT;
        state_d     = CTRL_FIRST_FETCH;
      end

      CTRL_FIRST_FETCH: begin
        ctrl_busy_o = 1'b1;
        instr_req_o = 1'b1;
        state_d     = CTRL_DECODE;
      end

      CTRL_DECODE: begin
        ctrl_busy_o = 1'b1;
        instr_req_o = 1'b1;
        if (exc_req) begin
          halt_id_o   = 1'b1;
          exc_latch   = 1'b1;
          exc_flag_d  = 1'b1;
          eret_flag_d = 1'b0;
          state_d     = CTRL_FLUSH;
        end else if (instr_valid_i && mret_insn_i) begin
          halt_id_o   = 1'b1;
          exc_flag_d  = 1'b0;
          eret_flag_d = 1'b1;
          state_d     = CTRL_FLUSH;
        end else if (WfiEnable && instr_valid_i && wfi_insn_i) begin
          // WFI itself retires; sleep starts on the following cycle.
          state_d = CTRL_SLEEP;
        end
      end

      CTRL_FLUSH: begin
        // Single-cycle redirect; anything raised now is deliberately ignored
        // so a trap can never nest inside its own flush.
        ctrl_busy_o = 1'b1;
        instr_req_o = 1'b1;
        flush_id_o  = 1'b1;
        pc_set_o    = 1'b1;
        if (exc_flag_q) begin
          pc_mux           = PC_EXC;
          csr_save_id_o    = 1'b1;
          csr_save_cause_o = 1'b1;
        end else if (eret_flag_q) begin
          pc_mux = PC_ERET;
        end
        exc_flag_d  = 1'b0;
        eret_flag_d = 1'b0;
        state_d     = CTRL_DECODE;
      end

      CTRL_SLEEP: begin
        if (irq_pending_i) begin
          state_d = CTRL_DECODE;
        end
      end

      default: begin
        state_d = CTRL_RESET;
      end
    endcase
  end

  assign pc_mux_o      = pc_mux;
  assign csr_save_if_o = 1'b0;
  assign csr_mcause_o  = mcause_q;
  assign csr_mtval_o   = mtval_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CTRL_RESET;
      exc_flag_q  <= 1'b0;
      eret_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exc_flag_q  <= exc_flag_d;
      eret_flag_q <= eret_flag_d;
    end
  end

  // Cause/value hold until the next exception so the CSR file can sample
  // them in the FLUSH cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (exc_latch) begin
      mcause_q <= exc_cause;
      mtval_q  <= exc_val;
    end
  end

endmodule

// File: tb/tb_qcv_controller.sv
// tb/tb_qcv_controller.sv - self-checking bench for qcv_controller

module tb_qcv_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_enable_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_id_i;
  logic        instr_fetch_err_i;
  logic        illegal_insn_i;
  logic        ecall_insn_i;
  logic        ebreak_insn_i;
  logic        mret_insn_i;
  logic        wfi_insn_i;
  logic        lsu_load_err_i;
  logic        lsu_store_err_i;
  logic [31:0] lsu_addr_i;
  logic        irq_pending_i;
  logic        ctrl_busy_o;
  logic        instr_req_o;
  logic        pc_set_o;
  logic [1:0]  pc_mux_o;
  logic        flush_id_o;
  logic        halt_id_o;
  logic        csr_mtvec_init_o;
  logic        csr_save_if_o;
  logic        csr_save_id_o;
  logic        csr_save_cause_o;
  logic [6:0]  csr_mcause_o;
  logic [31:0] csr_mtval_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0]  m_cause;
  logic [31:0] m_tval;

  qcv_controller #(.WfiEnable(1'b1)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .fetch_enable_i    (fetch_enable_i),
    .instr_valid_i     (instr_valid_i),
    .instr_i           (instr_i),
    .pc_id_i           (pc_id_i),
    .instr_fetch_err_i (instr_fetch_err_i),
    .illegal_insn_i    (illegal_insn_i),
    .ecall_insn_i      (ecall_insn_i),
    .ebreak_insn_i     (ebreak_insn_i),
    .mret_insn_i       (mret_insn_i),
    .wfi_insn_i        (wfi_insn_i),
    .lsu_load_err_i    (lsu_load_err_i),
    .lsu_store_err_i   (lsu_store_err_i),
    .lsu_addr_i        (lsu_addr_i),
    .irq_pending_i     (irq_pending_i),
    .ctrl_busy_o       (ctrl_busy_o),
    .instr_req_o       (instr_req_o),
    .pc_set_o          (pc_set_o),
    .pc_mux_o          (pc_mux_o),
    .flush_id_o        (flush_id_o),
    .halt_id_o         (halt_id_o),
    .csr_mtvec_init_o  (csr_mtvec_init_o),
    .csr_save_if_o     (csr_save_if_o),
    .csr_save_id_o     (csr_save_id_o),
    .csr_save_cause_o  (csr_save_cause_o),
    .csr_mcause_o      (csr_mcause_o),
    .csr_mtval_o       (csr_mtval_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic busy, input logic req,
                          input logic pcset, input logic [1:0] mux, input bit chk_mux,
                          input logic flush, input logic halt, input logic init,
                          input logic sid, input logic scause);
    chk({tag, ".busy"}, {31'b0, ctrl_busy_o}, {31'b0, busy});
    chk({tag, ".req"}, {31'b0, instr_req_o}, {31'b0, req});
    chk({tag, ".pc_set"}, {31'b0, pc_set_o}, {31'b0, pcset});
    if (chk_mux) chk({tag, ".pc_mux"}, {30'b0, pc_mux_o}, {30'b0, mux});
    chk({tag, ".flush"}, {31'b0, flush_id_o}, {31'b0, flush});
    chk({tag, ".halt"}, {31'b0, halt_id_o}, {31'b0, halt});
    chk({tag, ".mtvec_init"}, {31'b0, csr_mtvec_init_o}, {31'b0, init});
    chk({tag, ".save_if"}, {31'b0, csr_save_if_o}, 32'd0);
    chk({tag, ".save_id"}, {31'b0, csr_save_id_o}, {31'b0, sid});
    chk({tag, ".save_cause"}, {31'b0, csr_save_cause_o}, {31'b0, scause});
  endtask

  task automatic chk_csr(input string tag);
    chk({tag, ".mcause"}, {25'b0, csr_mcause_o}, {25'b0, m_cause});
    chk({tag, ".mtval"}, csr_mtval_o, m_tval);
  endtask

  task automatic clear_inputs();
    instr_valid_i     = 1'b0;
    instr_i           = '0;
    pc_id_i           = '0;
    instr_fetch_err_i = 1'b0;
    illegal_insn_i    = 1'b0;
    ecall_insn_i      = 1'b0;
    ebreak_insn_i     = 1'b0;
    mret_insn_i       = 1'b0;
    wfi_insn_i        = 1'b0;
    lsu_load_err_i    = 1'b0;
    lsu_store_err_i   = 1'b0;
    lsu_addr_i        = '0;
    irq_pending_i     = 1'b0;
  endtask

  task automatic rand_inputs();
    clear_inputs();
    instr_valid_i     = ($urandom_range(0, 3) != 0);
    instr_i           = $urandom;
    pc_id_i           = $urandom & 32'hFFFF_FFFC;
    instr_fetch_err_i = ($urandom_range(0, 7) == 0);
    illegal_insn_i    = ($urandom_range(0, 5) == 0);
    ecall_insn_i      = ($urandom_range(0, 6) == 0);
    ebreak_insn_i     = ($urandom_range(0, 6) == 0);
    mret_insn_i       = ($urandom_range(0, 4) == 0);
    wfi_insn_i        = ($urandom_range(0, 3) == 0);
    lsu_load_err_i    = ($urandom_range(0, 7) == 0);
    lsu_store_err_i   = ($urandom_range(0, 7) == 0);
    lsu_addr_i        = $urandom;
  endtask

  // Traffic that would trap if it were seen in DECODE; in FLUSH it must vanish.
  task automatic drive_junk();
    instr_valid_i     = 1'b1;
    instr_i           = $urandom;
    pc_id_i           = $urandom;
    instr_fetch_err_i = $urandom_range(0, 1);
    illegal_insn_i    = $urandom_range(0, 1);
    ecall_insn_i      = 1'b1;
    lsu_load_err_i    = $urandom_range(0, 1);
    lsu_store_err_i   = 1'b1;
    lsu_addr_i        = $urandom;
  endtask

  // Reference rule set: walk the exception sources in priority order; first
  // active one wins. Returns 0 none, 1 exception, 2 mret, 3 wfi.
  function automatic int classify(output logic [6:0] code, output logic [31:0] val);
    logic        hit   [6];
    int          codes [6];
    logic [31:0] vals  [6];
    hit[0] = instr_valid_i & instr_fetch_err_i; codes[0] = 1;  vals[0] = pc_id_i;
    hit[1] = instr_valid_i & illegal_insn_i;    codes[1] = 2;  vals[1] = instr_i;
    hit[2] = instr_valid_i & ecall_insn_i;      codes[2] = 11; vals[2] = 32'd0;
    hit[3] = instr_valid_i & ebreak_insn_i;     codes[3] = 3;  vals[3] = 32'd0;
    hit[4] = lsu_store_err_i;                   codes[4] = 7;  vals[4] = lsu_addr_i;
    hit[5] = lsu_load_err_i;                    codes[5] = 5;  vals[5] = lsu_addr_i;
    code = '0;
    val  = '0;
    for (int i = 0; i < 6; i++) begin
      if (hit[i]) begin
        code = codes[i][6:0];
        val  = vals[i];
        return 1;
      end
    end
    if (instr_valid_i && mret_insn_i) return 2;
    if (instr_valid_i && wfi_insn_i) return 3;
    return 0;
  endfunction

  // Entered at posedge+1 in RESET with reset released; leaves in DECODE.
  task automatic boot(input string tag);
    for (int c = 1; c <= 2; c++) begin
      #3;
      chk_outs($sformatf("%s.reset%0d", tag, c), 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0);
      chk_csr({tag, ".reset"});
      step();
    end
    fetch_enable_i = 1'b1;
    #3 chk_outs({tag, ".init"}, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0, 0);
    step();
    fetch_enable_i = 1'b0;
    #3 chk_outs({tag, ".boot_set"}, 1, 1, 1, 2'd0, 1, 0, 0, 0, 0, 0);
    step();
    #3 chk_outs({tag, ".first_fetch"}, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  // Entered at posedge+1 in DECODE with inputs already driven.
  task automatic run_decode(input string tag, input bit junk);
    int          kind;
    logic [6:0]  c;
    logic [31:0] v;
    bit          early;
    int          nslp;
    kind  = classify(c, v);
    early = 1'b0;
    if (kind == 3) begin
      early         = $urandom_range(0, 1);
      irq_pending_i = early;
    end
    #3;
    chk_outs({tag, ".id"}, 1, 1, 0, 2'd0, 0, 0, (kind == 1 || kind == 2), 0, 0, 0);
    chk_csr({tag, ".id"});
    step();
    clear_inputs();
    case (kind)
      1: begin
        m_cause = c;
        m_tval  = v;
        if (junk) drive_junk();
        #3 chk_outs({tag, ".flush_exc"}, 1, 1, 1, 2'd1, 1, 1, 0, 0, 1, 1);
        chk_csr({tag, ".flush_exc"});
        step();
        clear_inputs();
      end
      2: begin
        if (junk) drive_junk();
        #3 chk_outs({tag, ".flush_eret"}, 1, 1, 1, 2'd2, 1, 1, 0, 0, 0, 0);
        step();
        clear_inputs();
      end
      3: begin
        irq_pending_i = early;
        if (!early) begin
          nslp = $urandom_range(0, 2);
          for (int k = 0; k < nslp; k++) begin
            #3 chk_outs({tag, ".sleep"}, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
            step();
          end
          irq_pending_i = 1'b1;
        end
        #3 chk_outs({tag, ".sleep_wake"}, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        step();
        irq_pending_i = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    clear_inputs();
    fetch_enable_i = 1'b0;
    rst_ni         = 1'b0;
    m_cause        = '0;
    m_tval         = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    boot("boot");

    // Illegal instruction
    instr_valid_i = 1'b1; illegal_insn_i = 1'b1; instr_i = 32'hFFFF_FFFF;
    run_decode("illegal", 1'b0);
    chk("illegal.mcause_const", {25'b0, csr_mcause_o}, 32'd2);
    chk("illegal.mtval_const", csr_mtval_o, 32'hFFFF_FFFF);

    // Priority cases
    instr_valid_i = 1'b1; illegal_insn_i = 1'b1; ecall_insn_i = 1'b1; instr_i = 32'h0000_0073;
    run_decode("ill_ecall", 1'b0);
    chk("ill_ecall.mcause_const", {25'b0, csr_mcause_o}, 32'd2);
    instr_valid_i = 1'b1; ecall_insn_i = 1'b1; instr_i = 32'h0000_0073;
    run_decode("ecall", 1'b0);
    chk("ecall.mcause_const", {25'b0, csr_mcause_o}, 32'd11);
    chk("ecall.mtval_const", csr_mtval_o, 32'd0);
    instr_valid_i = 1'b1; mret_insn_i = 1'b1; ebreak_insn_i = 1'b1;
    run_decode("mret_ebreak", 1'b0);
    chk("mret_ebreak.mcause_const", {25'b0, csr_mcause_o}, 32'd3);

    // Store fault, then the same pulse repeated during FLUSH
    lsu_store_err_i = 1'b1; lsu_addr_i = 32'h1000_0003;
    run_decode("store", 1'b0);
    chk("store.mcause_const", {25'b0, csr_mcause_o}, 32'd7);
    chk("store.mtval_const", csr_mtval_o, 32'h1000_0003);
    lsu_store_err_i = 1'b1; lsu_addr_i = 32'h1000_0003;
    classify_and_flush_pulse();

    // MRET and WFI
    instr_valid_i = 1'b1; mret_insn_i = 1'b1;
    run_decode("mret", 1'b1);
    instr_valid_i = 1'b1; wfi_insn_i = 1'b1;
    run_decode("wfi", 1'b0);
    instr_valid_i = 1'b0;
    run_decode("after_wfi", 1'b0);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      rand_inputs();
      run_decode($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of FLUSH
    instr_valid_i = 1'b1; illegal_insn_i = 1'b1; instr_i = $urandom;
    #3 chk("rst_flush.halt", {31'b0, halt_id_o}, 32'd1);
    step();
    clear_inputs();
    rst_ni = 1'b0;
    #1;
    m_cause = '0;
    m_tval  = '0;
    chk_outs("rst_flush.async", 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0);
    chk_csr("rst_flush.async");
    step();
    step();
    rst_ni = 1'b1;
    boot("reboot");
    instr_valid_i = 1'b1; ebreak_insn_i = 1'b1;
    run_decode("reboot_ebreak", 1'b0);
    run_decode("reboot_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Store fault taken, then the identical pulse during FLUSH must not cause a
  // second save or overwrite mcause/mtval.
  task automatic classify_and_flush_pulse();
    lsu_addr_i = 32'h1000_0003;
    m_cause    = 7'd7;
    m_tval     = 32'h1000_0003;
    #3 chk("store2.halt", {31'b0, halt_id_o}, 32'd1);
    step();
    lsu_store_err_i = 1'b1;
    lsu_addr_i      = 32'h2000_0000;
    #3 chk("store2.flush_save", {31'b0, csr_save_cause_o}, 32'd1);
    step();
    clear_inputs();
    #3 chk("store2.no_second_save", {31'b0, csr_save_cause_o}, 32'd0);
    chk("store2.no_flush", {31'b0, flush_id_o}, 32'd0);
    chk_csr("store2.hold");
    step();
  endtask

endmodule
